silife_spi_matrix_driver: RTL and testbench

Parametrised SPI streamer that pushes a Game-of-Life grid band to a daisy-chain of MAX7219 8x8 LED matrix controllers. It replaces the fixed single-display SPI output of `silife`: the number of chained matrices and the SCK rate are parameters, and frames are requested explicitly. It sits between the grid row-read port and the `spi_cs` / `spi_sck` / `spi_mosi` pads.

---
 rtl/silife_spi_matrix_driver.sv | 213 +++++++++++++++++++++
 tb/tb_silife_spi_matrix_driver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_spi_matrix_driver.sv
// SPI streamer pushing an 8-row grid band to a daisy chain of MAX7219 matrix drivers.
// Define SILIFE_SPI_INIT_EN to send the MAX7219 init/intensity broadcast ahead of frames.
module silife_spi_matrix_driver #(
  parameter int MATRICES = 4,
  parameter int CLK_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_frame_start,
  input  logic [3:0]            i_brightness,
  output logic [2:0]            o_row_addr,
  input  logic [8*MATRICES-1:0] i_row_data,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  spi_cs,
  output logic                  spi_sck,
  output logic                  spi_mosi
);

  localparam int SR_W  = 16 * MATRICES;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(SR_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_W - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
`ifdef SILIFE_SPI_INIT_EN
  localparam logic [2:0] ST_INIT  = 3'd4;
`endif

  logic [2:0]       state;
  logic             pending;
  logic [2:0]       row;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  row_word;
  logic [SR_W-1:0]  load_word;
  logic             start_req;

  assign start_req  = (pending | i_frame_start) & i_enable;
  assign o_busy     = (state != ST_IDLE);
  assign o_row_addr = row;

  // Digit register address is row+1; the word for the farthest matrix goes out first.
  always_comb begin
    row_word = '0;
    for (int m = 0; m < MATRICES; m++) begin
      row_word[16*m +: 16] = {4'h0, {1'b0, row} + 4'd1, i_row_data[8*m +: 8]};
    end
  end

`ifdef SILIFE_SPI_INIT_EN
  logic [2:0]      init_idx;
  logic            init_done;
  logic            in_init;
  logic [3:0]      sent_brightness;
  logic [15:0]     init_cmd;
  logic [SR_W-1:0] init_word;

  always_comb begin
    case (init_idx)
      3'd0:    init_cmd = 16'h0C01;
      3'd1:    init_cmd = 16'h0B07;
      3'd2:    init_cmd = 16'h0900;
      3'd3:    init_cmd = 16'h0F00;
      default: init_cmd = {8'h0A, 4'h0, i_brightness};
    endcase
  end

  assign init_word = {MATRICES{init_cmd}};
  assign load_word = (state == ST_INIT) ? init_word : row_word;
`else
  logic brightness_unused;
  assign brightness_unused = ^i_brightness;
  assign load_word = row_word;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      row          <= 3'd0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sreg         <= '0;
      o_frame_done <= 1'b0;
      spi_cs       <= 1'b1;
      spi_sck      <= 1'b0;
      spi_mosi     <= 1'b0;
`ifdef SILIFE_SPI_INIT_EN
      init_idx        <= 3'd0;
      init_done       <= 1'b0;
      in_init         <= 1'b0;
      sent_brightness <= 4'h0;
`endif
    end else begin
      o_frame_done <= 1'b0;

      // Requests merge into one flag; it is consumed only when a frame starts.
      if (state == ST_IDLE && start_req) begin
        pending <= 1'b0;
      end else if (i_frame_start) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          spi_cs  <= 1'b1;
          spi_sck <= 1'b0;
          if (start_req) begin
            row <= 3'd0;
`ifdef SILIFE_SPI_INIT_EN
            if (!init_done) begin
              init_idx <= 3'd0;
              in_init  <= 1'b1;
              state    <= ST_INIT;
            end else if (i_brightness != sent_brightness) begin
              init_idx <= 3'd4;
              in_init  <= 1'b1;
              state    <= ST_INIT;
            end else begin
              state <= ST_LOAD;
            end
`else
            state <= ST_LOAD;
`endif
          end
        end

`ifdef SILIFE_SPI_INIT_EN
        ST_LOAD, ST_INIT: begin
          if (state == ST_INIT && init_idx == 3'd4) begin
            sent_brightness <= i_brightness;
          end
`else
        ST_LOAD: begin
`endif
          sreg     <= load_word;
          spi_mosi <= load_word[SR_W-1];
          spi_cs   <= 1'b0;
          spi_sck  <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= ST_SHIFT;
        end

        // Mode 0: data is set up while SCK is low and advanced on the SCK falling edge.
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                spi_cs   <= 1'b1;
                spi_mosi <= 1'b0;
                state    <= ST_LATCH;
              end else begin
                bit_cnt  <= bit_cnt + BIT_W'(1);
                sreg     <= sreg << 1;
                spi_mosi <= sreg[SR_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_LATCH: begin
          spi_cs <= 1'b1;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
`ifdef SILIFE_SPI_INIT_EN
            if (in_init) begin
              if (!i_enable) begin
                in_init <= 1'b0;
                state   <= ST_IDLE;
              end else if (init_idx == 3'd4) begin
                init_done <= 1'b1;
                in_init   <= 1'b0;
                state     <= ST_LOAD;
              end else begin
                init_idx <= init_idx + 3'd1;
                state    <= ST_INIT;
              end
            end else
`endif
            if (row == 3'd7) begin
              o_frame_done <= 1'b1;
              state        <= ST_IDLE;
            end else if (i_enable) begin
              row   <= row + 3'd1;
              state <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_silife_spi_matrix_driver.sv
// Bench for silife_spi_matrix_driver: decodes SPI traffic and compares it with a frame-level model.
// Expects the init broadcast when SILIFE_SPI_INIT_EN is defined.
module tb_silife_spi_matrix_driver;

  localparam int M    = 2;
  localparam int C    = 2;
  localparam int SR_W = 16 * M;
  localparam int T    = 1 + 32 * M * C + C;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_enable;
  logic           i_frame_start;
  logic [3:0]     i_brightness;
  logic [2:0]     o_row_addr;
  logic [8*M-1:0] i_row_data;
  logic           o_busy;
  logic           o_frame_done;
  logic           spi_cs;
  logic           spi_sck;
  logic           spi_mosi;

  logic [8*M-1:0] grid [8];
  assign i_row_data = grid[o_row_addr];

  always #5 clk = ~clk;

  silife_spi_matrix_driver #(.MATRICES(M), .CLK_DIV(C)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_frame_start(i_frame_start),
    .i_brightness(i_brightness), .o_row_addr(o_row_addr), .i_row_data(i_row_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .spi_cs(spi_cs),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              nbits;
    logic [SR_W-1:0] data;
    int              low_cycles;
  } txn_t;

  txn_t            cap_q[$];
  int              done_cyc[$];
  int              done_count = 0;
  int              mosi_glitch = 0;
  logic            prev_sck, prev_cs, prev_mosi;
  int              nbits_r, low_r;
  logic [SR_W-1:0] data_r;

  // SPI receiver: shifts MOSI on SCK rising edges, closes a word on CS rising.
  always @(negedge clk) begin
    if (reset) begin
      prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
      nbits_r = 0; low_r = 0; data_r = '0;
    end else begin
      if (o_frame_done) begin
        done_count++;
        done_cyc.push_back(cyc);
      end
      if (!spi_cs) begin
        low_r++;
        if (spi_sck && !prev_sck) begin
          data_r = {data_r[SR_W-2:0], spi_mosi};
          nbits_r++;
        end
        if (spi_sck && prev_sck && spi_mosi !== prev_mosi) mosi_glitch++;
      end else if (!prev_cs) begin
        cap_q.push_back('{nbits_r, data_r, low_r});
        nbits_r = 0; low_r = 0; data_r = '0;
      end
      prev_sck = spi_sck; prev_cs = spi_cs; prev_mosi = spi_mosi;
    end
  end

  // Frame-level reference: the word list each frame must put on the wire.
  logic [SR_W-1:0] exp_q[$];
  int              n_init;
`ifdef SILIFE_SPI_INIT_EN
  logic            model_init_done = 1'b0;
  logic [3:0]      model_sent_br = 4'h0;
`endif

  function automatic logic [SR_W-1:0] replicate(input logic [15:0] cmd);
    logic [SR_W-1:0] v = '0;
    for (int m = 0; m < M; m++) v = (v << 16) | SR_W'(cmd);
    return v;
  endfunction

  function automatic logic [SR_W-1:0] row_txn(input int r, input logic [8*M-1:0] d);
    logic [SR_W-1:0] v = '0;
    for (int m = M - 1; m >= 0; m--) v = v * 65536 + SR_W'((r + 1) * 256 + int'(d[8*m +: 8]));
    return v;
  endfunction

  task automatic model_frame();
    n_init = 0;
`ifdef SILIFE_SPI_INIT_EN
    if (!model_init_done) begin
      exp_q.push_back(replicate(16'h0C01));
      exp_q.push_back(replicate(16'h0B07));
      exp_q.push_back(replicate(16'h0900));
      exp_q.push_back(replicate(16'h0F00));
      exp_q.push_back(replicate({12'h0A0, i_brightness}));
      n_init = 5;
    end else if (i_brightness != model_sent_br) begin
      exp_q.push_back(replicate({12'h0A0, i_brightness}));
      n_init = 1;
    end
    model_init_done = 1'b1;
    model_sent_br   = i_brightness;
`endif
    for (int r = 0; r < 8; r++) exp_q.push_back(row_txn(r, grid[r]));
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One-cycle frame request; req_cyc marks the cycle the pulse is high.
  task automatic applyStimulus();
    @(posedge clk); #1;
    i_frame_start = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    i_frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int budget = 0;
    while (done_count < target && budget < 40 * T) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " done reached"}, 64'(done_count), 64'(target));
  endtask

  task automatic check_frame(input string tag, input int n_frames);
    checkOutput({tag, " txn count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s word%0d", tag, i), 64'(cap_q[i].data), 64'(exp_q[i]));
      checkOutput($sformatf("%s bits%0d", tag, i), 64'(cap_q[i].nbits), 64'(SR_W));
      checkOutput($sformatf("%s cs_low%0d", tag, i), 64'(cap_q[i].low_cycles), 64'(32 * M * C));
    end
    if (done_cyc.size() > 0)
      checkOutput({tag, " latency"}, 64'(done_cyc[done_cyc.size()-1] - req_cyc),
                  64'(exp_q.size() * T + n_frames));
    checkOutput({tag, " mosi stable"}, 64'(mosi_glitch), 64'd0);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_cond_cs_low(input string tag);
    int budget = 0;
    while (spi_cs !== 1'b0 && budget < 40 * T) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " cs low seen"}, 64'(spi_cs), 64'd0);
  endtask

  typedef struct {
    logic [15:0] row0;
    logic [31:0] first;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    int first_idx;
    vecs[0] = '{16'hA55A, 32'h01A5015A};
    vecs[1] = '{16'h0000, 32'h01000100};
    vecs[2] = '{16'hFFFF, 32'h01FF01FF};
    vecs[3] = '{16'h8001, 32'h01800101};

    reset = 1'b1; i_enable = 1'b1; i_frame_start = 1'b0; i_brightness = 4'h9;
    for (int r = 0; r < 8; r++) grid[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cs", 64'(spi_cs), 64'd1);
    checkOutput("reset sck", 64'(spi_sck), 64'd0);
    checkOutput("reset mosi", 64'(spi_mosi), 64'd0);
    checkOutput("reset row_addr", 64'(o_row_addr), 64'd0);
    checkOutput("reset busy", 64'(o_busy), 64'd0);
    checkOutput("reset done", 64'(o_frame_done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] table-driven row-0 frames");
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 8; r++) grid[r] = (8*M)'($urandom);
      grid[0] = vecs[i].row0;
      model_frame();
      first_idx = n_init;
      d0 = done_count;
      applyStimulus();
      wait_done(d0 + 1, $sformatf("vec%0d", i));
      if (cap_q.size() > first_idx)
        checkOutput($sformatf("vec%0d first row word", i), 64'(cap_q[first_idx].data), 64'(vecs[i].first));
      else
        checkOutput($sformatf("vec%0d first row present", i), 64'(cap_q.size()), 64'(first_idx + 1));
      check_frame($sformatf("vec%0d", i), 1);
    end

    $display("[TB] randomized frames");
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) grid[r] = (8*M)'($urandom);
      if (k == 2) i_brightness = 4'h3;
      model_frame();
      d0 = done_count;
      applyStimulus();
      wait_done(d0 + 1, $sformatf("rand%0d", k));
      check_frame($sformatf("rand%0d", k), 1);
    end

    $display("[TB] merged requests");
    for (int r = 0; r < 8; r++) grid[r] = (8*M)'($urandom);
    model_frame();
    model_frame();
    d0 = done_count;
    applyStimulus();
    for (int p = 0; p < 3; p++) begin
      repeat (150) @(posedge clk);
      #1 i_frame_start = 1'b1;
      @(posedge clk); #1 i_frame_start = 1'b0;
    end
    wait_done(d0 + 2, "merged");
    if (done_cyc.size() >= 2)
      checkOutput("merged back-to-back", 64'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]),
                  64'(8 * T + 1));
    check_frame("merged", 2);
    repeat (3 * T) @(negedge clk);
    checkOutput("merged no third frame", 64'(done_count), 64'(d0 + 2));
    checkOutput("merged idle", 64'(o_busy), 64'd0);

    $display("[TB] enable drop during row 3");
    for (int r = 0; r < 8; r++) grid[r] = (8*M)'($urandom);
    model_frame();
    while (exp_q.size() > n_init + 4) void'(exp_q.pop_back());
    d0 = done_count;
    applyStimulus();
    begin
      int budget = 0;
      while (!(o_row_addr == 3'd3 && spi_cs == 1'b0) && budget < 40 * T) begin
        @(negedge clk);
        budget++;
      end
      checkOutput("drop reached row3 shift", 64'(o_row_addr), 64'd3);
      repeat (20) @(posedge clk);
      #1 i_enable = 1'b0;
      budget = 0;
      while (o_busy && budget < 4 * T) begin
        @(negedge clk);
        budget++;
      end
    end
    checkOutput("drop went idle", 64'(o_busy), 64'd0);
    checkOutput("drop no done", 64'(done_count), 64'(d0));
    checkOutput("drop txn count", 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("drop word%0d", i), 64'(cap_q[i].data), 64'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
    i_enable = 1'b1;
    repeat (2 * T) @(negedge clk);
    checkOutput("drop stays idle", 64'(o_busy), 64'd0);
    checkOutput("drop no restart", 64'(cap_q.size()), 64'd0);

    $display("[TB] async reset during shift");
    applyStimulus();
    wait_cond_cs_low("areset");
    repeat (37) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset cs", 64'(spi_cs), 64'd1);
    checkOutput("areset sck", 64'(spi_sck), 64'd0);
    checkOutput("areset mosi", 64'(spi_mosi), 64'd0);
    checkOutput("areset busy", 64'(o_busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cap_q.delete();
`ifdef SILIFE_SPI_INIT_EN
    model_init_done = 1'b0;
`endif
    for (int r = 0; r < 8; r++) grid[r] = (8*M)'($urandom);
    model_frame();
    d0 = done_count;
    applyStimulus();
    wait_done(d0 + 1, "after reset");
    check_frame("after reset", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
